ram_nxw: RTL

RAM_NXW -- requirements
Module: ram_nxw

---
 rtl/ram_nxw.sv | 74 +++++++
 1 files changed

// File: rtl/ram_nxw.sv
// ram_nxw: DEPTH x WIDTH RAM with zero/ones sweep controller; optional parity via RAM_NXW_PARITY_EN
module ram_nxw #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             we,
    input  logic             re,
    input  logic             preset,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] din,
`ifdef RAM_NXW_PARITY_EN
    input  logic             perr_inject,
    output logic             perr,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy
);
`ifdef RAM_NXW_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [WIDTH-1:0] all_ones = '1;
    typedef enum logic [1:0] {INIT, IDLE, FILL} state_t;
    state_t state, state_n;
    logic [AW-1:0] ptr, ptr_n, wr_addr;
    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] din_word, ones_word, wr_word;
    logic sweep, wr_en, rd_en;
`ifdef RAM_NXW_PARITY_EN
    assign din_word  = {^din ^ perr_inject, din};
    assign ones_word = {^all_ones, all_ones};
`else
    assign din_word  = din;
    assign ones_word = all_ones;
`endif
    always_comb begin
        sweep   = state != IDLE;
        state_n = sweep ? (ptr == AW'(DEPTH - 1) ? IDLE : state) : (preset ? FILL : IDLE);
        ptr_n   = sweep ? ptr + 1'b1 : ptr;
        wr_en   = clear & (sweep | (we & ~preset));
        wr_addr = sweep ? ptr : address;
        wr_word = state == INIT ? '0 : state == FILL ? ones_word : din_word;
        rd_en   = ~sweep & re & ~preset;
    end
    always_ff @(posedge clk) begin
        if (!clear) begin
            state <= INIT;
            ptr   <= '0;
            busy  <= 1'b1;
            dout  <= '0;
            valid <= 1'b0;
`ifdef RAM_NXW_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            busy  <= state_n != IDLE;
            valid <= rd_en;
            if (rd_en) dout <= mem[address][WIDTH-1:0];
`ifdef RAM_NXW_PARITY_EN
            perr  <= rd_en & (^mem[address]);
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_word;
    end
endmodule
